bcd_freq_ctrl: RTL and testbench
================================

BCD_FREQ_CTRL -- requirements
Module: bcd_freq_ctrl

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 25000000, which is the gate window length in char_clock cycles; the legal range is 2..2^32-1.
REQ-002 The block SHALL have parameter LATCH_LINE, default 480, which is the line_count value at which the display value may change (outside the digit window).
REQ-003 char_clock  input  1  Sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  Asynchronous, active-low reset.
REQ-005 run  input  1  Measurement enable, level-sensitive.
REQ-006 sig_in  input  1  Measured signal, asynchronous to char_clock.
REQ-007 char_count  input  12  Horizontal position from the VGA timing block.
REQ-008 line_count  input  12  Vertical position from the VGA timing block.
REQ-009 bcd_cnt  output  32  Displayed result as 8 packed BCD digits, most significant digit in [31:28]; feeds the digit renderer.
REQ-010 overflow  output  1  Set when the displayed result saturated.
REQ-011 gate_active  output  1  High while a gate window is running.
REQ-012 meas_valid  output  1  One-cycle pulse when bcd_cnt updates.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer plus one edge-detect flop; a rising edge on the synchronized signal produces a one-cycle edge strobe.
REQ-014 The FSM SHALL have two states: IDLE and GATE.
- IDLE -> GATE on run=1; timer and BCD accumulator are cleared on entry.
- GATE -> IDLE on run=0, which aborts the window: no result is produced and the accumulator and timer are cleared.
REQ-015 In GATE, a 32-bit timer SHALL count 0..GATE_CYCLES-1, and gate_active SHALL be 1 exactly while the state is GATE.
REQ-016 Each edge strobe in GATE SHALL increment the 8-digit BCD accumulator by 1 in the same cycle.
- Digit carry ripples within the cycle (9 -> 0, carry into the next digit).
- Edge strobes in IDLE are ignored.
REQ-017 The accumulator SHALL saturate at 32'h99999999; an increment at saturation sets a per-window overflow flag and leaves the value unchanged.
REQ-018 At the terminal cycle (timer = GATE_CYCLES-1, state GATE, run=1):
- an edge in that cycle is included;
- the accumulator value (including that edge) and the overflow flag are copied to a pending register, and pending_flag is set;
- the accumulator, timer and overflow flag are cleared, and the state stays in GATE, so back-to-back windows have zero dead time.
REQ-019 Latch point: line_count == LATCH_LINE and char_count == 0. At a latch point with pending_flag=1:
- bcd_cnt <= pending value and overflow <= pending overflow;
- meas_valid = 1 for that cycle;
- pending_flag is cleared.
With pending_flag=0 there is no change and no pulse.
REQ-020 If a new window completes while pending_flag=1, the pending value SHALL be overwritten, so only the newest result is displayed.
REQ-021 If the terminal cycle and a latch point coincide, the display SHALL take the old pending value (if pending_flag was set), and the new result SHALL become pending with pending_flag=1.
REQ-022 bcd_cnt and overflow SHALL change only at latch points, never mid-frame, and SHALL hold their value through run=0.
REQ-023 Latency from a sig_in rising edge to the accumulator increment SHALL be 3 cycles.

Reset
REQ-024 reset_n=0 SHALL immediately force: state IDLE, bcd_cnt=0, overflow=0, gate_active=0, meas_valid=0, pending_flag=0, accumulator, timer and synchronizer flops all 0.
REQ-025 Reset mid-window SHALL discard all partial and pending results; after release, operation restarts from IDLE.

Verification (GATE_CYCLES=100, LATCH_LINE=480 unless stated)
REQ-026 run=1 with sig_in rising every 4 cycles, aligned so that 25 strobes fall in the window -> at the next latch point, bcd_cnt=32'h00000025 and meas_valid pulses exactly once.
REQ-027 GATE_CYCLES=300 with sig_in toggling every cycle (150 strobes) -> bcd_cnt=32'h00000150, confirming carries 9->10 and 99->100.
REQ-028 run dropped at timer=50 -> gate_active=0 on the next cycle, no meas_valid, bcd_cnt unchanged, with an unchanged value at the next latch point.
REQ-029 Three windows complete with no latch point, then a latch point occurs -> bcd_cnt equals the third result and meas_valid pulses once.
REQ-030 Terminal cycle coinciding with a latch point, old pending=32'h00000012 and new result 32'h00000034 -> bcd_cnt=32'h00000012 that cycle, and 32'h00000034 at the following latch point.
REQ-031 reset_n pulsed low mid-window after a displayed value of 32'h00000025 -> all outputs 0 asynchronously; after release, the first meas_valid follows one full window plus a latch point.

Source files
------------

// File: rtl/bcd_freq_ctrl.sv
// bcd_freq_ctrl: gated frequency counter for a VGA readout. Rising edges of
// sig_in are counted in BCD over a fixed window of char_clock cycles, and the
// finished count is handed to the digit renderer only at one raster position
// outside the digit area, so the displayed value never tears mid-frame.
module bcd_freq_ctrl #(
    parameter int unsigned GATE_CYCLES = 25000000,
    parameter int unsigned LATCH_LINE  = 480
) (
    input  logic        char_clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        sig_in,
    input  logic [11:0] char_count,
    input  logic [11:0] line_count,
    output logic [31:0] bcd_cnt,
    output logic        overflow,
    output logic        gate_active,
    output logic        meas_valid
);

    localparam logic [31:0] TIMER_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [11:0] LATCH_ROW  = 12'(LATCH_LINE);
    localparam logic [31:0] BCD_MAX    = 32'h9999_9999;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t      state_q;
    logic        sync1_q, sync2_q, sync3_q;
    logic [31:0] timer_q;
    logic [31:0] acc_q;
    logic        ovf_q;
    logic [31:0] pend_val_q;
    logic        pend_ovf_q;
    logic        pend_flag_q;
    logic [31:0] bcd_cnt_q;
    logic        overflow_q;
    logic        gate_active_q;
    logic        meas_valid_q;

    logic [31:0] acc_d;
    logic        ovf_d;
    logic        edge_stb;
    logic        latch_pt;
    logic        terminal;

    // Add one to an 8-digit packed BCD value; the carry ripples from the
    // least significant digit upward within the same cycle.
    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two flops resynchronise sig_in; the third holds the previous synchronised
    // level so a rising edge becomes a one-cycle strobe.
    always_ff @(posedge char_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_stb = sync2_q & ~sync3_q;
    assign latch_pt = (line_count == LATCH_ROW) && (char_count == 12'd0);
    assign terminal = (timer_q == TIMER_LAST);

    // Accumulator value after this cycle's strobe, saturating at 99999999.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (edge_stb) begin
            if (acc_q == BCD_MAX) begin
                ovf_d = 1'b1;
            end else begin
                acc_d = bcd_inc(acc_q);
            end
        end
    end

    // Gate FSM with window timer, accumulator, pending result and display latch.
    always_ff @(posedge char_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_q       <= 32'd0;
            acc_q         <= 32'd0;
            ovf_q         <= 1'b0;
            pend_val_q    <= 32'd0;
            pend_ovf_q    <= 1'b0;
            pend_flag_q   <= 1'b0;
            bcd_cnt_q     <= 32'd0;
            overflow_q    <= 1'b0;
            gate_active_q <= 1'b0;
            meas_valid_q  <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            // The display reads the pending register as it was before this
            // edge, so a window finishing on a latch point stays pending.
            if (latch_pt && pend_flag_q) begin
                bcd_cnt_q    <= pend_val_q;
                overflow_q   <= pend_ovf_q;
                meas_valid_q <= 1'b1;
                pend_flag_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q       <= GATE;
                        gate_active_q <= 1'b1;
                        timer_q       <= 32'd0;
                        acc_q         <= 32'd0;
                        ovf_q         <= 1'b0;
                    end
                end
                GATE: begin
                    if (!run) begin
                        state_q       <= IDLE;
                        gate_active_q <= 1'b0;
                        timer_q       <= 32'd0;
                        acc_q         <= 32'd0;
                        ovf_q         <= 1'b0;
                    end else if (terminal) begin
                        // Window closes with this cycle's edge included; the
                        // next window starts immediately with no dead time.
                        pend_val_q  <= acc_d;
                        pend_ovf_q  <= ovf_d;
                        pend_flag_q <= 1'b1;
                        timer_q     <= 32'd0;
                        acc_q       <= 32'd0;
                        ovf_q       <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_d;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    gate_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_cnt     = bcd_cnt_q;
    assign overflow    = overflow_q;
    assign gate_active = gate_active_q;
    assign meas_valid  = meas_valid_q;

endmodule

// File: tb/tb_bcd_freq_ctrl.sv
// Bench for bcd_freq_ctrl: directed windows plus randomized traffic, checked
// by a scoreboard fed from a count-based reference model.
module tb_bcd_freq_ctrl;

    localparam int          G    = 100;
    localparam logic [11:0] LROW = 12'd480;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        sig_in;
    logic [11:0] char_count;
    logic [11:0] line_count;
    logic [31:0] bcd_cnt;
    logic        overflow;
    logic        gate_active;
    logic        meas_valid;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [32:0] exp_q[$];
    bit          in_gate    = 1'b0;
    int          t          = 0;
    int unsigned cnt        = 0;
    int unsigned pend_cnt   = 0;
    bit          pend_valid = 1'b0;
    logic        h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic        exp_gate = 1'b0;
    logic        exp_mv   = 1'b0;
    logic [31:0] exp_disp = 32'd0;
    logic        exp_ovf  = 1'b0;

    bcd_freq_ctrl #(
        .GATE_CYCLES(G),
        .LATCH_LINE (480)
    ) dut (
        .char_clock (clk),
        .reset_n    (reset_n),
        .run        (run),
        .sig_in     (sig_in),
        .char_count (char_count),
        .line_count (line_count),
        .bcd_cnt    (bcd_cnt),
        .overflow   (overflow),
        .gate_active(gate_active),
        .meas_valid (meas_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // decimal count -> {overflow, packed BCD}, saturating at 99999999
    function automatic logic [32:0] to_exp(input int unsigned n);
        logic [31:0] b;
        logic        o;
        int unsigned v;
        o = (n > 32'd99999999);
        v = o ? 32'd99999999 : n;
        b = 32'd0;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {o, b};
    endfunction

    // sig_in pattern giving exactly n rising edges early in a window
    function automatic logic pat(input int n, input int tt);
        if (n <= 0) return 1'b0;
        if (4 * n <= G) return (tt < 4 * n) && ((tt % 4 == 1) || (tt % 4 == 2));
        return (tt < 2 * n) && (tt % 2 == 1);
    endfunction

    task automatic model_reset();
        in_gate    = 1'b0;
        t          = 0;
        cnt        = 0;
        pend_cnt   = 0;
        pend_valid = 1'b0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        exp_gate   = 1'b0;
        exp_mv     = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: a sig_in rise counts three edges
    // after it is first sampled; windows are G counted cycles long.
    task automatic model_step(input logic r, input logic s, input logic l);
        logic strobe;
        strobe = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = s;
        exp_mv = 1'b0;
        if (l && pend_valid) begin
            exp_q.push_back(to_exp(pend_cnt));
            exp_mv     = 1'b1;
            pend_valid = 1'b0;
        end
        if (!in_gate) begin
            if (r) begin
                in_gate = 1'b1; t = 0; cnt = 0;
            end
        end else if (!r) begin
            in_gate = 1'b0; t = 0; cnt = 0;
        end else begin
            if (strobe) cnt++;
            if (t == G - 1) begin
                pend_cnt = cnt; pend_valid = 1'b1; cnt = 0; t = 0;
            end else begin
                t++;
            end
        end
        exp_gate = in_gate;
    endtask

    task automatic cycle(input logic r, input logic s, input logic l);
        run    = r;
        sig_in = s;
        if (l) begin
            line_count = LROW;
            char_count = 12'd0;
        end else begin
            line_count = 12'($urandom_range(0, 524));
            char_count = 12'($urandom_range(0, 799));
            if ($urandom_range(0, 3) == 0) line_count = LROW;
            if (line_count == LROW && char_count == 12'd0) char_count = 12'd1;
        end
        @(posedge clk);
        model_step(r, s, l);
        #1;
    endtask

    task automatic win(input int n, input bit lat_first, input bit lat_term);
        for (int i = 0; i < G; i++)
            cycle(1'b1, pat(n, t), (lat_first && i == 0) || (lat_term && i == G - 1));
    endtask

    // monitor / scoreboard
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("reset_outputs", 64'({bcd_cnt, overflow, gate_active, meas_valid}), 64'd0);
                exp_disp = 32'd0;
                exp_ovf  = 1'b0;
            end else begin
                chk("gate_active", 64'(gate_active), 64'(exp_gate));
                chk("meas_valid", 64'(meas_valid), 64'(exp_mv));
                if (meas_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h expected none at %0t", bcd_cnt, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", 64'({overflow, bcd_cnt}), 64'(e));
                        exp_disp = e[31:0];
                        exp_ovf  = e[32];
                    end
                end else begin
                    chk("display_hold", 64'({overflow, bcd_cnt}), 64'({exp_ovf, exp_disp}));
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b1;
        run        = 1'b0;
        sig_in     = 1'b0;
        char_count = 12'd1;
        line_count = 12'd0;
        #2 reset_n = 1'b0;
        #1 chk("por_async", 64'({bcd_cnt, overflow, gate_active, meas_valid}), 64'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // idle: edges and latch points are ignored
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);

        // 25 edges, last one on the terminal cycle
        win(25, 1'b0, 1'b0);
        win(0, 1'b1, 1'b0);
        chk("disp_25", 64'(bcd_cnt), 64'h25);

        // three windows without a latch point: only the newest is shown
        win(5, 1'b0, 1'b0);
        win(7, 1'b0, 1'b0);
        win(9, 1'b0, 1'b0);
        win(0, 1'b1, 1'b0);
        chk("disp_newest", 64'(bcd_cnt), 64'h09);

        // terminal cycle on a latch point
        win(12, 1'b0, 1'b0);
        win(34, 1'b0, 1'b1);
        chk("coincide_old", 64'(bcd_cnt), 64'h12);
        win(0, 1'b1, 1'b0);
        chk("coincide_new", 64'(bcd_cnt), 64'h34);

        // sig_in toggling every cycle: 50 strobes in the second window
        begin
            logic tog;
            tog = 1'b0;
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < G; i++) begin
                    tog = ~tog;
                    cycle(1'b1, tog, 1'b0);
                end
        end

        // latch the 50 at window start, then abort at timer 50
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2 * G && t != 50; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, i % 2 == 0);
        chk("abort_hold", 64'(bcd_cnt), 64'h50);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 299) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);

        // mid-window reset after displaying 25
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        win(25, 1'b0, 1'b0);
        win(0, 1'b1, 1'b0);
        chk("pre_reset_disp", 64'(bcd_cnt), 64'h25);
        for (int i = 0; i < 30; i++) cycle(1'b1, pat(25, t), 1'b0);
        #1 reset_n = 1'b0;
        #1 chk("mid_reset_async", 64'({bcd_cnt, overflow, gate_active, meas_valid}), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        win(10, 1'b0, 1'b0);
        win(0, 1'b1, 1'b0);
        chk("post_reset_disp", 64'(bcd_cnt), 64'h10);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
